// File: rtl/bmu_pipe.sv
// bmu_pipe: pipelined bit-manipulation unit; result is formed at stage 0, later stages only delay it.
module bmu_pipe #(
   parameter int WIDTH   = 32,
   parameter int LATENCY = 2,
   parameter int SAT_EN  = 0,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic [11:0]      op,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [1:0]       err_code,
   output logic [CNT_W-1:0] op_count
);
   localparam int LW = $clog2(WIDTH);
   logic               stall, accept, illegal, ovf_add, ovf_sub, lt;
   logic [WIDTH:0]     sum, dif;
   logic [WIDTH-1:0]   smax, smin, add_v, sub_v, sra_v, rol_v, res0;
   logic [2*WIDTH-1:0] rot2;
   logic [LW:0]        clz_v, pop_v;
   logic [LW-1:0]      sh;
   logic [1:0]         err0;
   logic [LATENCY-1:0] vld_q, vld_d;
   logic [WIDTH-1:0]   res_q [LATENCY];
   logic [WIDTH-1:0]   res_d [LATENCY];
   logic [1:0]         err_q [LATENCY];
   logic [1:0]         err_d [LATENCY];
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   assign stall     = out_valid && !out_ready;
   assign in_ready  = !stall && !flush;
   assign accept    = in_valid && in_ready;
   assign out_valid = vld_q[LATENCY-1];
   assign result    = res_q[LATENCY-1];
   assign err_code  = err_q[LATENCY-1];
   assign op_count  = cnt_q;
   assign sh      = b_in[LW-1:0];
   assign sum     = {a_in[WIDTH-1], a_in} + {b_in[WIDTH-1], b_in};
   assign dif     = {a_in[WIDTH-1], a_in} - {b_in[WIDTH-1], b_in};
   assign ovf_add = sum[WIDTH] ^ sum[WIDTH-1];
   assign ovf_sub = dif[WIDTH] ^ dif[WIDTH-1];
   assign smax    = {1'b0, {(WIDTH-1){1'b1}}};
   assign smin    = {1'b1, {(WIDTH-1){1'b0}}};
   // bit WIDTH of the extended sum is the true sign, so it picks the clamp direction
   assign add_v   = (SAT_EN != 0 && ovf_add) ? (sum[WIDTH] ? smin : smax) : sum[WIDTH-1:0];
   assign sub_v   = (SAT_EN != 0 && ovf_sub) ? (dif[WIDTH] ? smin : smax) : dif[WIDTH-1:0];
   assign sra_v   = $signed(a_in) >>> sh;
   assign rot2    = {a_in, a_in} << sh;
   assign rol_v   = rot2[2*WIDTH-1:WIDTH];
   assign lt      = $signed(a_in) < $signed(b_in);
   assign illegal = !$onehot(op);
   always_comb begin
      clz_v = (LW+1)'(WIDTH);
      pop_v = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (a_in[i]) clz_v = (LW+1)'(WIDTH - 1 - i);
         pop_v = pop_v + (LW+1)'(a_in[i]);
      end
   end
   assign res0 = illegal ? '0 :
                 op[0]   ? add_v :
                 op[1]   ? sub_v :
                 op[2]   ? a_in & b_in :
                 op[3]   ? a_in ^ b_in :
                 op[4]   ? a_in << sh :
                 op[5]   ? sra_v :
                 op[6]   ? rol_v :
                 op[7]   ? WIDTH'(lt) :
                 op[8]   ? (lt ? a_in : b_in) :
                 op[9]   ? WIDTH'(clz_v) :
                 op[10]  ? WIDTH'(pop_v) :
                 (a_in << 3) + b_in;
   assign err0 = illegal ? 2'b10 : ((op[0] && ovf_add) || (op[1] && ovf_sub)) ? 2'b01 : 2'b00;
   always_comb begin
      vld_d = vld_q;
      res_d = res_q;
      err_d = err_q;
      if (!stall) begin
         vld_d[0] = accept;
         res_d[0] = res0;
         err_d[0] = err0;
         for (int i = 1; i < LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            res_d[i] = res_q[i-1];
            err_d[i] = err_q[i-1];
         end
      end
      if (flush) vld_d = '0;
      cnt_d = cnt_q + CNT_W'(accept);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= '0;
         res_q <= '{default: '0};
         err_q <= '{default: '0};
         cnt_q <= '0;
      end else begin
         vld_q <= vld_d;
         res_q <= res_d;
         err_q <= err_d;
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: tb/tb_bmu_pipe.sv
// tb_bmu_pipe: directed checks of bmu_pipe; a saturating and a wrapping instance share all inputs.
module tb_bmu_pipe;
   localparam int N = 15;
   logic        clk = 0, rst = 1, in_valid = 0, flush = 0, out_ready = 1;
   logic [31:0] a_in = '0, b_in = '0;
   logic [11:0] op = '0;
   logic        in_ready, out_valid, in_ready0, out_valid0;
   logic [31:0] result, result0;
   logic [1:0]  err_code, err_code0;
   logic [3:0]  op_count, op_count0, exp_cnt;
   int          n_chk = 0, n_fail = 0;
   always #5 clk = ~clk;
   bmu_pipe #(.WIDTH(32), .LATENCY(2), .SAT_EN(1), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in), .b_in(b_in),
      .op(op), .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .err_code(err_code), .op_count(op_count));
   bmu_pipe #(.WIDTH(32), .LATENCY(2), .SAT_EN(0), .CNT_W(4)) dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .a_in(a_in), .b_in(b_in),
      .op(op), .flush(flush), .out_valid(out_valid0), .out_ready(out_ready), .result(result0),
      .err_code(err_code0), .op_count(op_count0));
   logic [11:0] t_op [N] = '{12'h001, 12'h001, 12'h002, 12'h002, 12'h004, 12'h008, 12'h010, 12'h020,
                             12'h080, 12'h100, 12'h800, 12'h001, 12'h005, 12'h000, 12'h200};
   logic [31:0] t_a  [N] = '{32'h5, 32'h7FFFFFFF, 32'h80000000, 32'hA, 32'hF0F0FFFF, 32'hF0F0FFFF,
                             32'h1, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFB, 32'h20000001,
                             32'h80000000, 32'h5, 32'h5, 32'h00010000};
   logic [31:0] t_b  [N] = '{32'h3, 32'h1, 32'h1, 32'h3, 32'h0FF0F00F, 32'h0FF0F00F, 32'h24, 32'h4,
                             32'h1, 32'h3, 32'h2, 32'h80000000, 32'h3, 32'h3, 32'h0};
   logic [31:0] t_s  [N] = '{32'h8, 32'h7FFFFFFF, 32'h80000000, 32'h7, 32'h00F0F00F, 32'hFF000FF0,
                             32'h10, 32'hF8000000, 32'h1, 32'hFFFFFFFB, 32'hA, 32'h80000000,
                             32'h0, 32'h0, 32'd15};
   logic [31:0] t_w  [N] = '{32'h8, 32'h80000000, 32'h7FFFFFFF, 32'h7, 32'h00F0F00F, 32'hFF000FF0,
                             32'h10, 32'hF8000000, 32'h1, 32'hFFFFFFFB, 32'hA, 32'h00000000,
                             32'h0, 32'h0, 32'd15};
   logic [1:0]  t_e  [N] = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
                             2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00};
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   // holds the request until accepted, giving up after a fixed number of cycles
   task automatic send(input logic [11:0] o, input logic [31:0] a, input logic [31:0] b);
      logic acc;
      int   k;
      op = o; a_in = a; b_in = b; in_valid = 1; k = 0;
      do begin
         acc = in_ready;
         step();
         k++;
      end while (!acc && k < 20);
      in_valid = 0;
      if (acc) exp_cnt++;
      else chk("send_timeout", 64'(acc), 64'(1'b1));
   endtask
   initial begin
      exp_cnt = 0;
      step(); step();
      rst = 0;
      chk("rst_out_valid", 64'(out_valid), 64'(1'b0));
      chk("rst_result", 64'(result), 64'h0);
      chk("rst_err", 64'(err_code), 64'h0);
      chk("rst_op_count", 64'(op_count), 64'h0);
      chk("rst_in_ready", 64'(in_ready), 64'(1'b1));
      // op registered at edge N is on the output for the consumer sampling at edge N+2
      for (int i = 0; i < N; i++) begin
         send(t_op[i], t_a[i], t_b[i]);
         chk($sformatf("v%0d_not_yet", i), 64'(out_valid), 64'(1'b0));
         step();
         chk($sformatf("v%0d_valid", i), 64'(out_valid), 64'(1'b1));
         chk($sformatf("v%0d_res_sat", i), 64'(result), 64'(t_s[i]));
         chk($sformatf("v%0d_res_wrap", i), 64'(result0), 64'(t_w[i]));
         chk($sformatf("v%0d_err_sat", i), 64'(err_code), 64'(t_e[i]));
         chk($sformatf("v%0d_err_wrap", i), 64'(err_code0), 64'(t_e[i]));
         chk($sformatf("v%0d_count", i), 64'(op_count), 64'(exp_cnt));
      end
      step();
      chk("drain_out_valid", 64'(out_valid0), 64'(1'b0));
      out_ready = 0;
      send(12'h200, 32'h0, 32'h0);
      send(12'h400, 32'hF0F00001, 32'h0);
      op = 12'h040; a_in = 32'h80000001; b_in = 32'h4; in_valid = 1;
      for (int c = 0; c < 3; c++) begin
         chk($sformatf("stall%0d_in_ready", c), 64'(in_ready), 64'(1'b0));
         chk($sformatf("stall%0d_valid", c), 64'(out_valid), 64'(1'b1));
         chk($sformatf("stall%0d_result", c), 64'(result), 64'd32);
         step();
      end
      chk("stall_count", 64'(op_count), 64'(exp_cnt));
      out_ready = 1;
      #1;
      chk("release_in_ready", 64'(in_ready), 64'(1'b1));
      step();
      in_valid = 0;
      exp_cnt++;
      chk("seq1_result", 64'(result), 64'd9);
      chk("seq1_err", 64'(err_code), 64'h0);
      step();
      chk("seq2_valid", 64'(out_valid), 64'(1'b1));
      chk("seq2_result", 64'(result), 64'h18);
      chk("seq2_err", 64'(err_code), 64'h0);
      step();
      chk("seq_drain", 64'(out_valid), 64'(1'b0));
      send(12'h001, 32'h1, 32'h2);
      send(12'h001, 32'h3, 32'h4);
      chk("pre_flush_valid", 64'(out_valid), 64'(1'b1));
      op = 12'h001; a_in = 32'h9; b_in = 32'h9; in_valid = 1; flush = 1;
      #1;
      chk("flush_in_ready", 64'(in_ready), 64'(1'b0));
      step();
      flush = 0; in_valid = 0;
      chk("flush_out_valid", 64'(out_valid), 64'(1'b0));
      chk("flush_count", 64'(op_count), 64'(exp_cnt));
      step();
      chk("flush_stage0_gone", 64'(out_valid), 64'(1'b0));
      rst = 1;
      step();
      rst = 0;
      exp_cnt = 0;
      for (int i = 0; i < 17; i++) send(12'h001, 32'h1, 32'h1);
      chk("wrap_count", 64'(op_count), 64'h1);
      chk("wrap_count_wrapinst", 64'(op_count0), 64'h1);
      rst = 1;
      step();
      rst = 0;
      chk("midrst_out_valid", 64'(out_valid), 64'(1'b0));
      chk("midrst_count", 64'(op_count), 64'h0);
      chk("midrst_in_ready", 64'(in_ready), 64'(1'b1));
      step();
      chk("midrst_no_late_out", 64'(out_valid), 64'(1'b0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/bmu_pipe.md
Name: bmu_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle bit-manipulation unit.
- Accepts one operation per cycle through a valid/ready handshake and carries it through LATENCY register stages with full backpressure.
- Returns the result with a 2-bit error code.
- Adds beyond the previous generation: configurable width, optional saturation on add/sub, and the clz, cpop, rol and sh3add ops.

Parameters:
- WIDTH, 32: operand/result width; power of two, 8..64.
- LATENCY, 2: pipeline stages from input accept to out_valid; 1..4.
- SAT_EN, 0: 1 = add/sub overflow clamps to signed max/min; 0 = wraps.
- CNT_W, 16: width of the accepted-operation counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept this cycle.
- a_in  in  WIDTH  operand A, signed.
- b_in  in  WIDTH  operand B, signed.
- op  in  12  one-hot op select: [0]add [1]sub [2]land [3]lxor [4]sll [5]sra [6]rol [7]slt [8]min [9]clz [10]cpop [11]sh3add.
- flush  in  1  discard all in-flight operations.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  operation result.
- err_code  out  2  00 ok, 01 overflow, 10 illegal op, 11 unused.
- op_count  out  CNT_W  number of accepted operations; wraps.

Behaviour:
- Reset (rst high at clk edge):
  - all stage valids clear; out_valid=0, result=0, err_code=00, op_count=0.
  - in_ready=1 in the first cycle after reset.
- Accept occurs when in_valid && in_ready. Accept increments op_count modulo 2^CNT_W.
- stall = out_valid && !out_ready.
  - in_ready = !stall (combinational).
  - On stall, every stage holds its contents; no bubble collapse.
- Without stall, an op accepted at edge N presents out_valid at edge N+LATENCY. Throughput is 1 op/cycle.
- The result is computed combinationally at stage 0 and the remaining stages are pure delay. result/err_code stay stable while out_valid && !out_ready.
- The output handshake completes on out_valid && out_ready. If no new op fills the last stage, out_valid falls the next cycle.
- Illegal op: op not exactly one-hot (zero or multiple bits). Result=0, err_code=10. It is still accepted and counted.
- Op semantics (modulo 2^WIDTH; shift amount = b_in[log2(WIDTH)-1:0]):
  - add/sub: computed at WIDTH+1 bits sign-extended. Overflow when bit WIDTH != bit WIDTH-1, and then err_code=01.
    - SAT_EN=0: low WIDTH bits.
    - SAT_EN=1: positive overflow -> 0111..1, negative overflow -> 1000..0.
  - land/lxor: bitwise.
  - sll: logical left shift.
  - sra: arithmetic right shift.
  - rol: rotate left.
  - slt: signed a<b -> 1 else 0.
  - min: signed minimum.
  - clz: count of leading zeros of a_in; a_in=0 gives WIDTH.
  - cpop: count of set bits of a_in.
  - sh3add: (a_in<<3)+b_in, wrapping, never flags overflow.
- flush, synchronous, one cycle:
  - clears all stage valids and out_valid next edge.
  - in_ready=0 during the flush cycle; any in_valid that cycle is not accepted and not counted.
  - op_count is unaffected.
- rst has priority over flush; flush has priority over accept.
- Reset mid-operation drops all in-flight ops with no output handshake.
- op_count wraps from 2^CNT_W-1 to 0 without error.

Test Plan:
- WIDTH=32, LATENCY=2: add 0x0000_0005+0x0000_0003 accepted at edge 0 -> out_valid at edge 2, result 0x0000_0008, err 00.
- SAT_EN=1: add 0x7FFF_FFFF+0x0000_0001 -> result 0x7FFF_FFFF, err 01. SAT_EN=0: same stimulus -> 0x8000_0000, err 01.
- op=12'b0000_0000_0101 (add|land) -> result 0, err 10, op_count increments. op=0 -> same response.
- Back-to-back clz(0x0000_0000), cpop(0xF0F0_0001), rol(0x8000_0001, b=4) with out_ready=0 for 3 cycles:
  - in_ready=0 while the stall persists; first result held stable.
  - After release, results in order: 32, 9, 0x0000_0018, each err 00.
- flush asserted with 2 ops in flight and in_valid=1 -> out_valid=0 next cycle, the flush-cycle input is not counted, op_count unchanged.
- CNT_W=4: 17 accepted ops -> op_count=1. rst asserted mid-stream -> next cycle out_valid=0, op_count=0, in_ready=1.
